// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: m0 has fixed priority, a starvation guard forces m1 through.
// Optional perf counters are enabled with `define DMEM_ARB_PERF_EN.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CW           = 4,
  parameter int ALEN         = 32,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [3:0]      m0_be,
  input  logic [2:0]      m0_funct3,
  input  logic [ALEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [XLEN-1:0] m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [3:0]      m1_be,
  input  logic [2:0]      m1_funct3,
  input  logic [ALEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [XLEN-1:0] m1_rdata,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [2:0]      mem_funct3,
  output logic [ALEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]     perf_m1_wait,
  output logic [31:0]     perf_forced
`endif
);

  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_starve_cnt;
  logic          r_pend;
  logic          r_owner;
  logic          w_force;
  logic          w_rd_gnt;

  // A zero limit compiles the guard away entirely (pure fixed priority).
  generate
    if (STARVE_LIMIT == 0) begin : g_noguard
      assign w_force = 1'b0;
    end else begin : g_guard
      assign w_force = (r_starve_cnt >= LIMIT);
    end
  endgenerate

  assign m1_gnt   = m1_req && (!m0_req || w_force);
  assign m0_gnt   = m0_req && !m1_gnt;
  assign w_rd_gnt = (m0_gnt && !m0_we) || (m1_gnt && !m1_we);

  always_comb begin
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_funct3 = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (m1_gnt) begin
      mem_we     = m1_we;
      mem_be     = m1_be;
      mem_funct3 = m1_funct3;
      mem_addr   = m1_addr;
      mem_wdata  = m1_wdata;
    end else if (m0_gnt) begin
      mem_we     = m0_we;
      mem_be     = m0_be;
      mem_funct3 = m0_funct3;
      mem_addr   = m0_addr;
      mem_wdata  = m0_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!m1_req || m1_gnt) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != {CW{1'b1}}) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Owner is only meaningful while pending; it tags the single in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend  <= 1'b0;
      r_owner <= 1'b0;
    end else begin
      r_pend <= w_rd_gnt;
      if (w_rd_gnt) r_owner <= m1_gnt;
    end
  end

  assign m0_rvalid = r_pend && !r_owner;
  assign m1_rvalid = r_pend && r_owner;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] r_perf_wait;
  logic [31:0] r_perf_forced;

  // m1 winning while m0 also requests can only happen through the guard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_wait   <= '0;
      r_perf_forced <= '0;
    end else begin
      if (m1_req && !m1_gnt && (r_perf_wait != 32'hFFFF_FFFF))
        r_perf_wait <= r_perf_wait + 32'd1;
      if (m1_gnt && m0_req && (r_perf_forced != 32'hFFFF_FFFF))
        r_perf_forced <= r_perf_forced + 32'd1;
    end
  end

  assign perf_m1_wait = r_perf_wait;
  assign perf_forced  = r_perf_forced;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, hand corner sequences, and a randomized run against a reference model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [3:0]  m0_be = 0, m1_be = 0;
  logic [2:0]  m0_funct3 = 0, m1_funct3 = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;
  // limit-0 instance
  logic        z_m0_gnt, z_m0_rvalid, z_m1_gnt, z_m1_rvalid, z_mem_we;
  logic [31:0] z_m0_rdata, z_m1_rdata, z_mem_addr, z_mem_wdata;
  logic [3:0]  z_mem_be;
  logic [2:0]  z_mem_funct3;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_m1_wait, perf_forced, z_perf_m1_wait, z_perf_forced;
`endif

  int tests = 0;
  int fails = 0;

  dmem_arbiter #(.STARVE_LIMIT(8), .CW(4), .ALEN(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_funct3(m0_funct3),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_funct3(m1_funct3),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_be(mem_be), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .perf_m1_wait(perf_m1_wait), .perf_forced(perf_forced)
`endif
  );

  dmem_arbiter #(.STARVE_LIMIT(0), .CW(4), .ALEN(32), .XLEN(32)) dut0 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_funct3(m0_funct3),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(z_m0_gnt),
    .m0_rvalid(z_m0_rvalid), .m0_rdata(z_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_funct3(m1_funct3),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(z_m1_gnt),
    .m1_rvalid(z_m1_rvalid), .m1_rdata(z_m1_rdata),
    .mem_we(z_mem_we), .mem_be(z_mem_be), .mem_funct3(z_mem_funct3),
    .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_rdata(32'h0)
`ifdef DMEM_ARB_PERF_EN
    , .perf_m1_wait(z_perf_m1_wait), .perf_forced(z_perf_forced)
`endif
  );

  always #5 clk = ~clk;

  function automatic int idx(input logic [31:0] a);
    return int'({a[31], a[6:2]});
  endfunction

  // Memory device behind the arbiter, 1-cycle read latency.
  logic [31:0] mem_dev [0:63];
  always @(posedge clk) begin
    mem_rdata <= mem_dev[idx(mem_addr)];
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem_dev[idx(mem_addr)][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  // Expected memory contents, updated from the requesters' own transactions.
  logic [31:0] shadow [0:63];
  initial
    for (int i = 0; i < 64; i++) begin
      mem_dev[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0011;
      shadow[i]  = 32'hA500_0000 + 32'(i) * 32'h0001_0011;
    end

  task automatic shadow_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (be[b]) shadow[idx(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m0_req = 0; m0_we = 0; m0_be = 0; m0_funct3 = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_be = 0; m1_funct3 = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic r0, w0, r1, w1;
    logic [31:0] a0, d0, a1, d1;
    logic e0, e1, ewe;
    logic [31:0] eaddr, ewdata;
  } vec_t;

  vec_t vt [8];

  // Reference model state for the randomized run.
  int          m_wait;
  logic        m_pend, m_own;
  logic [31:0] m_data;

  initial begin
    vt[0] = '{0,0, 0,0, 32'h0,  32'h0, 32'h0,  32'h0, 0,0, 0, 32'h0,  32'h0};
    vt[1] = '{1,0, 0,0, 32'h10, 32'h0, 32'h0,  32'h0, 1,0, 0, 32'h10, 32'h0};
    vt[2] = '{0,0, 1,1, 32'h0,  32'h0, 32'h24, 32'h1234_5678, 0,1, 1, 32'h24, 32'h1234_5678};
    vt[3] = '{1,0, 1,0, 32'h14, 32'h0, 32'h18, 32'h0, 1,0, 0, 32'h14, 32'h0};
    vt[4] = '{1,1, 0,0, 32'h8000_0004, 32'h41, 32'h0, 32'h0, 1,0, 1, 32'h8000_0004, 32'h41};
    vt[5] = '{1,1, 1,1, 32'h28, 32'hCAFE_0001, 32'h2C, 32'hBEEF_0002, 1,0, 1, 32'h28, 32'hCAFE_0001};
    vt[6] = '{0,0, 1,0, 32'h0,  32'h0, 32'h3C, 32'h0, 0,1, 0, 32'h3C, 32'h0};
    vt[7] = '{0,0, 0,0, 32'h0,  32'h0, 32'h0,  32'h0, 0,0, 0, 32'h0,  32'h0};

    // reset state
    idle_inputs();
    rst = 1'b1;
    #3;
    chk("rst_m0_rvalid", {31'b0, m0_rvalid}, 0);
    chk("rst_m1_rvalid", {31'b0, m1_rvalid}, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    step();
    rst = 1'b0;

    // vector table: grant + memory mux, starvation counter stays well below limit
    for (int i = 0; i < 8; i++) begin
      m0_req = vt[i].r0; m0_we = vt[i].w0; m0_addr = vt[i].a0; m0_wdata = vt[i].d0; m0_be = 4'hF;
      m1_req = vt[i].r1; m1_we = vt[i].w1; m1_addr = vt[i].a1; m1_wdata = vt[i].d1; m1_be = 4'hF;
      @(negedge clk);
      chk($sformatf("vec%0d_m0_gnt", i), {31'b0, m0_gnt}, {31'b0, vt[i].e0});
      chk($sformatf("vec%0d_m1_gnt", i), {31'b0, m1_gnt}, {31'b0, vt[i].e1});
      chk($sformatf("vec%0d_mem_we", i), {31'b0, mem_we}, {31'b0, vt[i].ewe});
      chk($sformatf("vec%0d_mem_addr", i), mem_addr, vt[i].eaddr);
      chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, vt[i].ewdata);
      if (vt[i].ewe) shadow_wr(vt[i].eaddr, 4'hF, vt[i].ewdata);
      step();
    end

    // Test 1: simultaneous reads, m0 wins, data steered to m0
    do_reset();
    m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_addr = 32'h20;
    @(negedge clk);
    chk("t1_m0_gnt", {31'b0, m0_gnt}, 1);
    chk("t1_m1_gnt", {31'b0, m1_gnt}, 0);
    step();
    idle_inputs();
    @(negedge clk);
    chk("t1_m0_rvalid", {31'b0, m0_rvalid}, 1);
    chk("t1_m0_rdata", m0_rdata, shadow[idx(32'h10)]);
    chk("t1_m1_rvalid", {31'b0, m1_rvalid}, 0);
    step();

    // Test 2: starvation guard forces m1 on the 9th waiting cycle
    do_reset();
    m0_req = 1; m0_addr = 32'h0; m1_req = 1; m1_addr = 32'h100;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk($sformatf("t2_c%0d_m1_gnt", c), {31'b0, m1_gnt}, {31'b0, c == 9});
      chk($sformatf("t2_c%0d_m0_gnt", c), {31'b0, m0_gnt}, {31'b0, c != 9});
      step();
    end
    @(negedge clk);
    chk("t2_after_m1_gnt", {31'b0, m1_gnt}, 0);
    chk("t2_m1_rvalid", {31'b0, m1_rvalid}, 1);
    chk("t2_m1_rdata", m1_rdata, shadow[idx(32'h100)]);
    chk("t2_m0_rvalid", {31'b0, m0_rvalid}, 0);
`ifdef DMEM_ARB_PERF_EN
    chk("t2_perf_forced", perf_forced, 1);
    chk("t2_perf_m1_wait", perf_m1_wait, 8);
`endif
    step();

    // Test 3: guard disabled, m1 waits as long as m0 requests
    do_reset();
    m0_req = 1; m0_addr = 32'h4; m1_req = 1; m1_addr = 32'h8;
    begin
      int bad = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (z_m1_gnt !== 1'b0) bad++;
        step();
      end
      chk("t3_m1_gnt_cycles", bad, 0);
    end
    m0_req = 0;
    @(negedge clk);
    chk("t3_m1_gnt_on_drop", {31'b0, z_m1_gnt}, 1);
    step();

    // Test 4: back-to-back reads from different owners
    do_reset();
    m0_req = 1; m0_addr = 32'h10;
    step();
    idle_inputs();
    m1_req = 1; m1_addr = 32'h20;
    @(negedge clk);
    chk("t4_c2_m0_rvalid", {31'b0, m0_rvalid}, 1);
    chk("t4_c2_m0_rdata", m0_rdata, shadow[idx(32'h10)]);
    chk("t4_c2_m1_rvalid", {31'b0, m1_rvalid}, 0);
    chk("t4_c2_m1_gnt", {31'b0, m1_gnt}, 1);
    step();
    idle_inputs();
    @(negedge clk);
    chk("t4_c3_m1_rvalid", {31'b0, m1_rvalid}, 1);
    chk("t4_c3_m1_rdata", m1_rdata, shadow[idx(32'h20)]);
    chk("t4_c3_m0_rvalid", {31'b0, m0_rvalid}, 0);
    chk("t4_c3_m0_rdata", m0_rdata, 0);
    step();

    // Test 5: m1 writes LEDs, m0 reads them back
    do_reset();
    m1_req = 1; m1_we = 1; m1_be = 4'hF; m1_addr = 32'h8000_0000; m1_wdata = 32'h5;
    @(negedge clk);
    chk("t5_mem_we", {31'b0, mem_we}, 1);
    chk("t5_mem_addr", mem_addr, 32'h8000_0000);
    shadow_wr(32'h8000_0000, 4'hF, 32'h5);
    step();
    idle_inputs();
    @(negedge clk);
    chk("t5_no_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 0);
    step();
    m0_req = 1; m0_addr = 32'h8000_0000;
    step();
    idle_inputs();
    @(negedge clk);
    chk("t5_led_rdata", m0_rdata, 32'h5);
    step();

    // Test 6: async reset lands between grant and return
    do_reset();
    m0_req = 1; m0_addr = 32'h30;
    @(posedge clk);
    #2;
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("t6_m0_rvalid", {31'b0, m0_rvalid}, 0);
    chk("t6_m0_rdata", m0_rdata, 0);
    chk("t6_mem_addr", mem_addr, 0);
    chk("t6_gnts", {30'b0, m0_gnt, m1_gnt}, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_after_m0_rvalid", {31'b0, m0_rvalid}, 0);
    step();

    // Randomized traffic against the reference model
    do_reset();
    m_wait = 0; m_pend = 0; m_own = 0; m_data = 0;
    begin
      int bad_g = 0, bad_r = 0;
      logic e0, e1;
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        e1 = m1_req && (!m0_req || m_wait >= 8);
        e0 = m0_req && !e1;
        if (m0_gnt !== e0 || m1_gnt !== e1) begin
          bad_g++;
          if (bad_g < 5) $display("FAIL rnd_gnt: got %b%b expected %b%b at %0t", m0_gnt, m1_gnt, e0, e1, $time);
        end
        if (m0_rvalid !== (m_pend && !m_own) || m1_rvalid !== (m_pend && m_own) ||
            m0_rdata !== ((m_pend && !m_own) ? m_data : 32'h0) ||
            m1_rdata !== ((m_pend && m_own) ? m_data : 32'h0)) begin
          bad_r++;
          if (bad_r < 5) $display("FAIL rnd_ret: got %b/%h %b/%h expected owner %b pend %b data %h at %0t",
                                  m0_rvalid, m0_rdata, m1_rvalid, m1_rdata, m_own, m_pend, m_data, $time);
        end
        m_pend = 0;
        if (e0 && !m0_we) begin m_pend = 1; m_own = 0; m_data = shadow[idx(m0_addr)]; end
        if (e1 && !m1_we) begin m_pend = 1; m_own = 1; m_data = shadow[idx(m1_addr)]; end
        if (e0 && m0_we) shadow_wr(m0_addr, m0_be, m0_wdata);
        if (e1 && m1_we) shadow_wr(m1_addr, m1_be, m1_wdata);
        m_wait = (m1_req && !e1) ? ((m_wait < 15) ? m_wait + 1 : 15) : 0;
        step();
        if (e0) m0_req = 0;
        if (e1) m1_req = 0;
        if (!m0_req && ($urandom_range(0, 7) != 0)) begin
          m0_req = 1; m0_we = $urandom_range(0, 2) == 0; m0_be = 4'($urandom_range(1, 15));
          m0_funct3 = 3'($urandom); m0_wdata = $urandom;
          m0_addr = ($urandom_range(0, 3) == 0 ? 32'h8000_0000 : 32'h0) | (32'($urandom_range(0, 31)) << 2);
        end
        if (!m1_req && ($urandom_range(0, 3) == 0)) begin
          m1_req = 1; m1_we = $urandom_range(0, 1) == 0; m1_be = 4'($urandom_range(1, 15));
          m1_funct3 = 3'($urandom); m1_wdata = $urandom;
          m1_addr = ($urandom_range(0, 3) == 0 ? 32'h8000_0000 : 32'h0) | (32'($urandom_range(0, 31)) << 2);
        end
      end
      chk("rnd_gnt_errors", bad_g, 0);
      chk("rnd_return_errors", bad_r, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
